// File: rtl/spi_readout_framer_pkg.sv
// Shared definitions for the SPI readout framer: state encoding,
// default sync byte and payload byte-count derivation.
package we_readout_pkg;

    localparam int DATA_WIDTH_DEF = 40;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SYNC,
        ST_SEQ,
        ST_DATA,
        ST_CKSUM
    } state_e;

    function automatic int nbytes(input int dw);
        return dw / 8;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_readout_framer_if.sv
// FIFO read side and framed byte stream of the readout framer.
// master = framer, slave = FIFO/sink environment.
interface spi_readout_framer_if
    import we_readout_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic [7:0]            byte_data;
    logic                  byte_valid;
    logic                  byte_ready;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  byte_ready,
        output fifo_rd_en,
        output byte_data,
        output byte_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output byte_ready,
        input  fifo_rd_en,
        input  byte_data,
        input  byte_valid
    );
endinterface

// File: rtl/spi_readout_framer.sv
// Pops SPI result words and frames them as SYNC, SEQ, payload MSB-first.
// Define READOUT_CKSUM_EN to append a mod-256 checksum byte per frame.
module spi_readout_framer
    import we_readout_pkg::*;
#(
    parameter int         DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    spi_readout_framer_if.master bus,
    output logic                 busy,
    output logic [15:0]          frame_cnt
);

    localparam int NBYTES = nbytes(DATA_WIDTH);
    localparam int IDXW   = idx_w(NBYTES);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_nxt;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [7:0]            seq_q, seq_d;
    logic [7:0]            bdata_q, bdata_d;
    logic                  bvalid_q, bvalid_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  rd_en, xfer, last;
`ifdef READOUT_CKSUM_EN
    logic [7:0]            ck_q, ck_d;
`endif

    assign rd_en     = ~rst & enable & ~bus.fifo_empty
                     & (state_q == ST_IDLE);
    assign xfer      = bvalid_q & bus.byte_ready;
    assign shift_nxt = shift_q << 8;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        seq_d    = seq_q;
        bdata_d  = bdata_q;
        bvalid_d = bvalid_q;
        cnt_d    = cnt_q;
        last     = 1'b0;
`ifdef READOUT_CKSUM_EN
        ck_d     = ck_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rd_en) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                shift_d  = bus.fifo_rd_data;
                idx_d    = IDXW'(NBYTES - 1);
                bdata_d  = SYNC_BYTE;
                bvalid_d = 1'b1;
                state_d  = ST_SYNC;
`ifdef READOUT_CKSUM_EN
                ck_d     = seq_q;
`endif
            end
            ST_SYNC: begin
                if (xfer) begin
                    bdata_d = seq_q;
                    state_d = ST_SEQ;
                end
            end
            ST_SEQ: begin
                if (xfer) begin
                    bdata_d = shift_q[DATA_WIDTH-1 -: 8];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
`ifdef READOUT_CKSUM_EN
                    ck_d = ck_q + bdata_q;
`endif
                    if (idx_q == '0) begin
`ifdef READOUT_CKSUM_EN
                        bdata_d = ck_q + bdata_q;
                        state_d = ST_CKSUM;
`else
                        last = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q - IDXW'(1);
                        shift_d = shift_nxt;
                        bdata_d = shift_nxt[DATA_WIDTH-1 -: 8];
                    end
                end
            end
            ST_CKSUM: begin
`ifdef READOUT_CKSUM_EN
                if (xfer) last = 1'b1;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        // Final byte accepted: close the frame and free the bus.
        if (last) begin
            state_d  = ST_IDLE;
            bvalid_d = 1'b0;
            bdata_d  = 8'h00;
            seq_d    = seq_q + 8'd1;
            cnt_d    = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            seq_q    <= 8'h00;
            bdata_q  <= 8'h00;
            bvalid_q <= 1'b0;
            cnt_q    <= 16'h0000;
`ifdef READOUT_CKSUM_EN
            ck_q     <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            bdata_q  <= bdata_d;
            bvalid_q <= bvalid_d;
            cnt_q    <= cnt_d;
`ifdef READOUT_CKSUM_EN
            ck_q     <= ck_d;
`endif
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.byte_data  = bdata_q;
    assign bus.byte_valid = bvalid_q;
    assign busy           = (state_q != ST_IDLE);
    assign frame_cnt      = cnt_q;

endmodule

// File: tb/tb_spi_readout_framer.sv
// Randomized bench for spi_readout_framer with a queue-based frame model
// and a per-cycle compare process.
module tb_spi_readout_framer;
    import we_readout_pkg::*;

    localparam int DW = 40;
    localparam int NB = DW / 8;
`ifdef READOUT_CKSUM_EN
    localparam int FL = NB + 3;
    localparam bit CK = 1'b1;
`else
    localparam int FL = NB + 2;
    localparam bit CK = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } eb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        busy;
    logic [15:0] frame_cnt;

    spi_readout_framer_if #(.DATA_WIDTH(DW)) bus();

    spi_readout_framer #(
        .DATA_WIDTH(DW),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .bus      (bus.master),
        .busy     (busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo[$];
    eb_t           exp[$];
    logic [7:0]    got[$];
    logic [15:0]   m_cnt = 16'd0;
    logic [7:0]    m_seq = 8'd0;
    bit            m_busy = 1'b0;
    int            cyc = 0;
    int            pop_cyc = -10;
    int            n_pops = 0;
    bit            rand_ready = 1'b0;
    int            tests = 0;
    int            fails = 0;
    eb_t           e;
    logic [DW-1:0] w;

    function automatic void chk(string nm, logic [63:0] a, logic [63:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, a, x, cyc);
        end
    endfunction

    // Expected bytes of one frame, straight from the framing rules.
    function automatic void add_frame(logic [DW-1:0] word, logic [7:0] s);
        int         sum;
        logic [7:0] b;
        sum = int'(s);
        exp.push_back({8'hA5, 1'b0});
        exp.push_back({s, 1'b0});
        for (int i = NB - 1; i >= 0; i--) begin
            b = 8'((word >> (8 * i)) & 'hFF);
            sum += int'(b);
            exp.push_back({b, (!CK && i == 0)});
        end
        if (CK) exp.push_back({8'(sum % 256), 1'b1});
    endfunction

    always begin
        @(negedge clk);
        bus.fifo_empty = (fifo.size() == 0);
        bus.byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        cyc++;
        chk("fifo_rd_en", 64'(bus.fifo_rd_en),
            64'(!rst && enable && !bus.fifo_empty && !m_busy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
        chk("byte_valid", 64'(bus.byte_valid),
            64'(m_busy && cyc != pop_cyc + 1));
        if (bus.byte_valid && exp.size() > 0)
            chk("byte_data", 64'(bus.byte_data), 64'(exp[0].b));
        if (cyc == pop_cyc + 2)
            chk("sync_latency", 64'({bus.byte_valid, bus.byte_data}), 64'({1'b1, 8'hA5}));
        if (rst) begin
            exp.delete();
            m_busy  = 1'b0;
            m_seq   = 8'd0;
            m_cnt   = 16'd0;
            pop_cyc = -10;
        end else begin
            if (bus.byte_valid && bus.byte_ready && exp.size() > 0) begin
                e = exp.pop_front();
                got.push_back(bus.byte_data);
                if (e.last) begin
                    m_cnt++;
                    m_busy = 1'b0;
                end
            end
            if (bus.fifo_rd_en && fifo.size() > 0) begin
                w = fifo.pop_front();
                bus.fifo_rd_data = w;
                add_frame(w, m_seq);
                m_seq++;
                m_busy  = 1'b1;
                pop_cyc = cyc;
                n_pops++;
            end
        end
    end

    task automatic wait_drain(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fifo.size() == 0 && !m_busy && exp.size() == 0) && n < max);
        chk("drain_done", 64'(n < max), 64'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_got(input int cnt, input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (got.size() < cnt && n < max);
        chk("got_bytes", 64'(got.size() >= cnt), 64'(1));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        n_pops = 0;
    endtask

    logic [7:0] t2 [8];

    initial begin
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = '0;
        bus.byte_ready   = 1'b1;
        t2 = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'h59};
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;

        // Idle with an empty FIFO.
        repeat (50) @(negedge clk);
        chk("t1_pops", 64'(n_pops), 64'(0));
        chk("t1_cnt", 64'(frame_cnt), 64'(0));
        chk("t1_valid", 64'(bus.byte_valid), 64'(0));

        // Single known word.
        got.delete();
        fifo.push_back(40'h01_2345_6789);
        wait_drain(100);
        chk("t2_len", 64'(got.size()), 64'(FL));
        for (int i = 0; i < FL; i++)
            chk($sformatf("t2_byte%0d", i), 64'(got[i]), 64'(t2[i]));
        chk("t2_cnt", 64'(frame_cnt), 64'(1));

        // Three words under random backpressure.
        pulse_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 3; i++) fifo.push_back({$urandom, $urandom});
        wait_drain(400);
        rand_ready = 1'b0;
        chk("t3_pops", 64'(n_pops), 64'(3));
        chk("t3_seq0", 64'(got[1]), 64'(8'h00));
        chk("t3_seq1", 64'(got[FL + 1]), 64'(8'h01));
        chk("t3_seq2", 64'(got[2 * FL + 1]), 64'(8'h02));
        chk("t3_cnt", 64'(frame_cnt), 64'(3));

        // Enable dropped mid-frame.
        pulse_reset();
        fifo.push_back({$urandom, $urandom});
        fifo.push_back({$urandom, $urandom});
        wait_got(1, 50);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        chk("t4_pops", 64'(n_pops), 64'(1));
        chk("t4_cnt", 64'(frame_cnt), 64'(1));
        chk("t4_len", 64'(got.size()), 64'(FL));
        enable = 1'b1;
        wait_drain(100);
        chk("t4_pops2", 64'(n_pops), 64'(2));
        chk("t4_seq1", 64'(got[FL + 1]), 64'(8'h01));

        // Reset in the middle of the payload.
        pulse_reset();
        fifo.push_back({$urandom, $urandom});
        wait_got(4, 50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("t5_valid", 64'(bus.byte_valid), 64'(0));
        chk("t5_data", 64'(bus.byte_data), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_cnt", 64'(frame_cnt), 64'(0));
        got.delete();
        fifo.push_back({$urandom, $urandom});
        wait_drain(100);
        chk("t5_len", 64'(got.size()), 64'(FL));
        chk("t5_seq", 64'(got[1]), 64'(8'h00));

        // Sequence number wrap.
        pulse_reset();
        for (int i = 0; i < 257; i++) fifo.push_back({$urandom, $urandom});
        wait_drain(257 * (FL + 4) + 100);
        chk("t6_cnt", 64'(frame_cnt), 64'(257));
        chk("t6_pops", 64'(n_pops), 64'(257));
        chk("t6_seq255", 64'(got[255 * FL + 1]), 64'(8'hFF));
        chk("t6_seq256", 64'(got[256 * FL + 1]), 64'(8'h00));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
